// File: rtl/approx_mult_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// approx_mult_pkg
// Shared types and step tables for the sequential 16x16 approximate
// multiplier controller (approx_mult_seq_ctrl).
//   state_t     : controller state (IDLE / MUL / DONE)
//   step_t      : 2-bit byte-pair step index
//   STEP_A_HI   : bit k set -> step k uses A[15:8], else A[7:0]
//   STEP_B_HI   : bit k set -> step k uses B[15:8], else B[7:0]
//   step_shift  : accumulator shift per step {0, 8, 8, 16}
//   sel_byte    : upper/lower byte select
//   step_mask   : per-step "both operand bytes nonzero" mask (zero-skip build)
//   next_active : lowest active step at or above a start index (zero-skip build)
// ---------------------------------------------------------------------------
package approx_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    // Steps 0..3: A lo/hi/lo/hi, B lo/lo/hi/hi.
    localparam logic [3:0] STEP_A_HI = 4'b1010;
    localparam logic [3:0] STEP_B_HI = 4'b1100;

    function automatic logic [4:0] step_shift(input step_t s);
        logic [4:0] sh;
        case (s)
            2'd0:    sh = 5'd0;
            2'd1:    sh = 5'd8;
            2'd2:    sh = 5'd8;
            2'd3:    sh = 5'd16;
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [3:0] step_mask(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] m;
        m = 4'd0;
        for (int k = 0; k < 4; k++) begin
            m[k] = (sel_byte(a, STEP_A_HI[k]) != 8'd0) && (sel_byte(b, STEP_B_HI[k]) != 8'd0);
        end
        return m;
    endfunction

    // Returns {found, step}; found=0 when no active step remains at or above 'from'.
    function automatic logic [2:0] next_active(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (!r[2] && mask[k] && (3'(k) >= from)) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_mult_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// approx_mult_seq_ctrl_if
// Operand/result handshake bundle of approx_mult_seq_ctrl.
//   in_valid/in_ready/A/B   : operand channel (source -> controller)
//   out_valid/out_ready/Z   : result channel (controller -> consumer)
// master = operand source + result consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface approx_mult_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Z;

    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Z);
    modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, Z);
endinterface

// File: rtl/approx_mult_seq_ctrl_mult8.sv
// ---------------------------------------------------------------------------
// approx_mult_8bit
// 8x8 multiplier core shared by the sequential controller.
//   ADDER_SEL = 0 : exact 16-bit product
//   ADDER_SEL != 0: approximate product, low nibble of the result truncated
// Ports: a, b (8-bit operands), p (16-bit product).
// ---------------------------------------------------------------------------
module approx_mult_8bit #(
    parameter int ADDER_SEL = 0
) (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] exact_s;

    assign exact_s = {8'd0, a} * {8'd0, b};

    generate
        if (ADDER_SEL == 0) begin : g_exact
            assign p = exact_s;
        end else begin : g_trunc
            assign p = {exact_s[15:4], 4'b0000};
        end
    endgenerate
endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// approx_mult_seq_ctrl
// Computes a 16x16 approximate product by stepping one approx_mult_8bit over
// the four byte pairs and accumulating shifted partial products exactly.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : approx_mult_seq_ctrl_if.slave (operand + result handshakes)
//   mult_en  : multiplier active this cycle (clock-gate enable)
//   busy     : controller not in IDLE
// Build option: APPROX_MULT_ZERO_SKIP_EN skips steps whose operand bytes
// include a zero byte (their contribution is 0).
// ---------------------------------------------------------------------------
module approx_mult_seq_ctrl
    import approx_mult_pkg::*;
#(
    parameter int ADDER_SEL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    approx_mult_seq_ctrl_if.slave   bus,
    output logic                    mult_en,
    output logic                    busy
);
    state_t      state_r;
    state_t      state_s;
    step_t       step_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [31:0] acc_r;
    logic [31:0] z_r;
    logic [7:0]  a_byte_s;
    logic [7:0]  b_byte_s;
    logic [15:0] pp_s;
    logic [31:0] acc_sum_s;
    logic        hs_s;
    logic        last_step_s;

    assign hs_s      = (state_r == ST_IDLE) && bus.in_valid;
    assign a_byte_s  = sel_byte(a_r, STEP_A_HI[step_r]);
    assign b_byte_s  = sel_byte(b_r, STEP_B_HI[step_r]);
    assign acc_sum_s = acc_r + ({16'd0, pp_s} << step_shift(step_r));

`ifdef APPROX_MULT_ZERO_SKIP_EN
    logic [3:0] mask_r;
    logic [3:0] hs_mask_s;
    logic [2:0] hs_first_s;
    logic [2:0] next_s;

    assign hs_mask_s   = step_mask(bus.A, bus.B);
    assign hs_first_s  = next_active(hs_mask_s, 3'd0);
    assign next_s      = next_active(mask_r, {1'b0, step_r} + 3'd1);
    assign last_step_s = ~next_s[2];
`else
    assign last_step_s = (step_r == 2'd3);
`endif

    approx_mult_8bit #(.ADDER_SEL(ADDER_SEL)) u_mult (
        .a (a_byte_s),
        .b (b_byte_s),
        .p (pp_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
`ifdef APPROX_MULT_ZERO_SKIP_EN
                    state_s = hs_first_s[2] ? ST_MUL : ST_DONE;
`else
                    state_s = ST_MUL;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_step_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register; in_ready is held low during reset.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        mult_en       = 1'b0;
        busy          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.in_ready = ~rst;
            end
            ST_MUL: begin
                mult_en = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.Z = z_r;

    // Operand capture, step sequencing, accumulation and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= 16'd0;
            b_r    <= 16'd0;
            acc_r  <= 32'd0;
            step_r <= 2'd0;
            z_r    <= 32'd0;
`ifdef APPROX_MULT_ZERO_SKIP_EN
            mask_r <= 4'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        a_r   <= bus.A;
                        b_r   <= bus.B;
                        acc_r <= 32'd0;
`ifdef APPROX_MULT_ZERO_SKIP_EN
                        mask_r <= hs_mask_s;
                        step_r <= hs_first_s[1:0];
                        // No active step: the product is defined as zero.
                        if (!hs_first_s[2]) begin
                            z_r <= 32'd0;
                        end else begin
                            z_r <= z_r;
                        end
`else
                        step_r <= 2'd0;
`endif
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_sum_s;
`ifdef APPROX_MULT_ZERO_SKIP_EN
                    step_r <= next_s[1:0];
`else
                    step_r <= step_r + 2'd1;
`endif
                    if (last_step_s) begin
                        z_r <= acc_sum_s;
                    end else begin
                        z_r <= z_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end
endmodule
